fetch_seq: RTL

Multi-cycle instruction-fetch sequencer for the NPC core. It owns the architectural PC and walks every instruction through request, response, issue and execute phases. It drives a valid/ready fetch port towards instruction memory and applies jump/branch redirects reported by the execute stage. It stops the core on `ebreak` (halt) or on a fetch error / misaligned target (fault).

---
 rtl/npc_pkg.sv | 25 ++
 rtl/fetch_seq_if.sv | 37 +++
 rtl/pc_next.sv | 33 +++
 rtl/fetch_seq.sv | 122 ++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared definitions for the NPC core fetch path.
//   XLEN          - address / instruction width
//   NPC_RESET_PC  - architectural PC value loaded on reset
//   fetch_state_e - fetch sequencer states
//   is_misaligned - true when an address is not word aligned
package npc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NPC_RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5,
    ST_FAULT = 3'd6
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: valid/ready instruction-fetch port between the fetch
// sequencer (master) and instruction memory (slave).
//   ifu_req_valid  master->slave  request valid
//   ifu_req_ready  slave->master  memory accepts request
//   ifu_req_addr   master->slave  fetch address
//   ifu_rsp_valid  slave->master  response valid
//   ifu_rsp_inst   slave->master  fetched instruction
//   ifu_rsp_err    slave->master  bus error, qualified by ifu_rsp_valid
interface fetch_seq_if;
  import npc_pkg::*;

  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_req_addr;
  logic            ifu_rsp_valid;
  logic [XLEN-1:0] ifu_rsp_inst;
  logic            ifu_rsp_err;

  modport master (
    output ifu_req_valid,
    output ifu_req_addr,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_inst,
    input  ifu_rsp_err
  );

  modport slave (
    input  ifu_req_valid,
    input  ifu_req_addr,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output ifu_rsp_inst,
    output ifu_rsp_err
  );

endinterface

// File: rtl/pc_next.sv
// pc_next: combinational next-PC select for the fetch sequencer.
//   cur_pc       in   current architectural PC
//   halt_req     in   ebreak retired (wins over redirect)
//   redir_en     in   taken jump/branch
//   redir_target in   absolute redirect target
//   next_pc      out  PC to load when execute completes
//   misaligned   out  redirect target is not word aligned
module pc_next
  import npc_pkg::*;
(
  input  logic [XLEN-1:0] cur_pc,
  input  logic            halt_req,
  input  logic            redir_en,
  input  logic [XLEN-1:0] redir_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic take_redir;

  assign take_redir = redir_en && !halt_req;
  assign misaligned = take_redir && is_misaligned(redir_target);

  always_comb begin
    next_pc = cur_pc + 32'd4; // natural 32-bit wrap FFFF_FFFC -> 0
    if (halt_req || misaligned) begin
      next_pc = cur_pc;
    end else if (take_redir) begin
      next_pc = redir_target;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: multi-cycle instruction-fetch sequencer. Owns the
// architectural PC and walks each instruction through
// FETCH -> WAIT -> ISSUE -> EXEC, stopping in HALT or FAULT.
//   clk, rst      clock, asynchronous active-high reset
//   bus           fetch port (fetch_seq_if.master)
//   inst_valid    one-cycle issue pulse
//   inst/inst_pc  latched instruction and its PC
//   exe_done      execute finished current instruction
//   redir_en      taken jump/branch, qualified by exe_done
//   redir_target  absolute redirect target
//   halt_req      ebreak retired, qualified by exe_done
//   pc            architectural PC
//   halted/fault  sticky stop indications
module fetch_seq #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = npc_pkg::NPC_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  fetch_seq_if.master     bus,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            exe_done,
  input  logic            redir_en,
  input  logic [XLEN-1:0] redir_target,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic            fault
);
  import npc_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q, inst_pc_q;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            pc_load;
  logic            inst_load;

  pc_next u_pc_next (
    .cur_pc       (pc_q),
    .halt_req     (halt_req),
    .redir_en     (redir_en),
    .redir_target (redir_target),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_load   = 1'b0;
    inst_load = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.ifu_req_ready) state_d = ST_WAIT;
      end
      // Responses are only looked at here, so one arriving in the
      // handshake cycle or during EXEC is dropped.
      ST_WAIT: begin
        if (bus.ifu_rsp_valid) begin
          if (bus.ifu_rsp_err) begin
            state_d = ST_FAULT;
          end else begin
            inst_load = 1'b1;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (exe_done) begin
          pc_load = 1'b1; // next_pc already holds pc on halt/misalign
          if (halt_req)        state_d = ST_HALT;
          else if (misaligned) state_d = ST_FAULT;
          else                 state_d = ST_FETCH;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (pc_load) begin
      pc_q <= next_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else if (inst_load) begin
      inst_q    <= bus.ifu_rsp_inst;
      inst_pc_q <= pc_q;
    end
  end

  assign bus.ifu_req_valid = (state_q == ST_FETCH);
  assign bus.ifu_req_addr  = pc_q;
  assign inst_valid        = (state_q == ST_ISSUE);
  assign inst              = inst_q;
  assign inst_pc           = inst_pc_q;
  assign pc                = pc_q;
  assign halted            = (state_q == ST_HALT);
  assign fault             = (state_q == ST_FAULT);

endmodule
